vec_elem_mul: RTL and testbench

- Element-wise IEEE-754 binary32 multiplier for two VECTOR_LEN vectors.
- Sits directly upstream of vec_elem_sum; together they form the dot-product path of a neuron. result feeds vec_elem_sum's vec, and done feeds its enable.
- Time-shares one fp32 multiplier and produces one element per cycle, using the same enable/done handshake as vec_elem_sum.

---
 rtl/vec_pkg.sv | 36 +++
 rtl/vec_elem_mul_if.sv | 24 ++
 rtl/fp32_mul.sv | 77 +++++++
 rtl/vec_elem_mul.sv | 130 +++++++++++++
 tb/tb_vec_elem_mul.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/vec_pkg.sv
// Shared types and constants for the element-wise fp32 multiply path.
package vec_pkg;

  typedef logic [31:0] fp32_t;

  localparam fp32_t FP32_QNAN    = 32'h7FC00000;
  localparam fp32_t FP32_POS_INF = 32'h7F800000;
  localparam int    FP32_BIAS    = 127;
  localparam int    FP32_EXP_W   = 8;
  localparam int    FP32_MAN_W   = 23;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  // Boundary between mantissa product and normalise/round.
  typedef struct packed {
    logic               special;
    fp32_t              spec_val;
    logic               sign;
    logic signed [9:0]  exp_sum;
    logic [47:0]        prod;
  } mul_mid_t;

  // Subnormals carry no weight here, so a zero exponent field means zero.
  function automatic logic fp32_is_zero(input fp32_t x);
    return x[30:23] == '0;
  endfunction

  function automatic logic fp32_is_inf(input fp32_t x);
    return (x[30:23] == '1) && (x[22:0] == '0);
  endfunction

  function automatic logic fp32_is_nan(input fp32_t x);
    return (x[30:23] == '1) && (x[22:0] != '0);
  endfunction

endpackage

// File: rtl/vec_elem_mul_if.sv
// Producer/consumer bundle for vec_elem_mul: enable/done handshake plus vectors.
interface vec_elem_mul_if
  import vec_pkg::*;
#(
  parameter int VECTOR_LEN = 4
);

  logic                         enable;
  fp32_t [VECTOR_LEN-1:0]       vec_a;
  fp32_t [VECTOR_LEN-1:0]       vec_b;
  fp32_t [VECTOR_LEN-1:0]       result;
  logic                         done;

  modport master (
    output enable, vec_a, vec_b,
    input  result, done
  );

  modport slave (
    input  enable, vec_a, vec_b,
    output result, done
  );

endinterface

// File: rtl/fp32_mul.sv
// binary32 multiplier, RNE, subnormals flushed. With VEC_ELEM_MUL_PIPE_EN a
// register sits between the mantissa product and normalise/round.
module fp32_mul
  import vec_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  fp32_t a,
  input  fp32_t b,
  output fp32_t p
);

  mul_mid_t mid_d, mid_q;

  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign a_zero = fp32_is_zero(a);
  assign b_zero = fp32_is_zero(b);
  assign a_inf  = fp32_is_inf(a);
  assign b_inf  = fp32_is_inf(b);
  assign a_nan  = fp32_is_nan(a);
  assign b_nan  = fp32_is_nan(b);

  always_comb begin
    mid_d          = '0;
    mid_d.sign     = a[31] ^ b[31];
    mid_d.prod     = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    mid_d.exp_sum  = 10'($signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - FP32_BIAS);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      mid_d.special  = 1'b1;
      mid_d.spec_val = FP32_QNAN;
    end else if (a_inf || b_inf) begin
      mid_d.special  = 1'b1;
      mid_d.spec_val = {mid_d.sign, FP32_POS_INF[30:0]};
    end else if (a_zero || b_zero) begin
      mid_d.special  = 1'b1;
      mid_d.spec_val = {mid_d.sign, 31'd0};
    end
  end

`ifdef VEC_ELEM_MUL_PIPE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mid_q <= '0;
    else     mid_q <= mid_d;
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;
  assign mid_q = mid_d;
`endif

  logic               nrm, g, r, s, rnd_up;
  logic [23:0]        mant;
  logic [24:0]        mant_r;
  logic [22:0]        frac;
  logic signed [9:0]  exp_n, exp_r;

  // Product of two 1.x mantissas lies in [1,4): at most one normalising shift.
  always_comb begin
    nrm    = mid_q.prod[47];
    mant   = nrm ? mid_q.prod[47:24] : mid_q.prod[46:23];
    g      = nrm ? mid_q.prod[23]    : mid_q.prod[22];
    r      = nrm ? mid_q.prod[22]    : mid_q.prod[21];
    s      = nrm ? |mid_q.prod[21:0] : |mid_q.prod[20:0];
    exp_n  = mid_q.exp_sum + (nrm ? 10'sd1 : 10'sd0);
    rnd_up = g & (r | s | mant[0]);
    mant_r = {1'b0, mant} + {24'd0, rnd_up};
    exp_r  = exp_n + (mant_r[24] ? 10'sd1 : 10'sd0);
    frac   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];

    if (mid_q.special)         p = mid_q.spec_val;
    else if (exp_r > 10'sd254) p = {mid_q.sign, FP32_POS_INF[30:0]};
    else if (exp_r < 10'sd1)   p = {mid_q.sign, 31'd0};
    else                       p = {mid_q.sign, exp_r[7:0], frac};
  end

endmodule

// File: rtl/vec_elem_mul.sv
// Element-wise fp32 vector multiply, one shared multiplier, one element/cycle.
// VEC_ELEM_MUL_PIPE_EN adds a multiplier register stage and a DRAIN step.
module vec_elem_mul
  import vec_pkg::*;
#(
  parameter int VECTOR_LEN = 4
)(
  input  logic           clk,
  input  logic           rst,
  vec_elem_mul_if.slave  bus
);

  localparam int IDX_W = (VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(VECTOR_LEN - 1);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    done_q, done_d;
  logic                    cap, iss;
  fp32_t [VECTOR_LEN-1:0]  opa_q, opb_q, res_q;

  logic                    wr_en;
  logic [IDX_W-1:0]        wr_idx;
  fp32_t                   mul_p;

  fp32_mul u_mul (
    .clk (clk),
    .rst (rst),
    .a   (opa_q[idx_q]),
    .b   (opb_q[idx_q]),
    .p   (mul_p)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = done_q;
    cap     = 1'b0;
    iss     = 1'b0;
    case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (bus.enable) begin
          cap     = 1'b1;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        iss   = 1'b1;
        idx_d = IDX_W'(idx_q + 1'b1);
        if (idx_q == LAST) begin
          idx_d = '0;
`ifdef VEC_ELEM_MUL_PIPE_EN
          state_d = DRAIN;
`else
          state_d = DONE;
          done_d  = 1'b1;
`endif
        end
      end
      DRAIN: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE: begin
        done_d = 1'b1;
        if (!bus.enable) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Operands are frozen at capture so producer changes mid-run are invisible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa_q <= '0;
      opb_q <= '0;
    end else if (cap) begin
      opa_q <= bus.vec_a;
      opb_q <= bus.vec_b;
    end
  end

`ifdef VEC_ELEM_MUL_PIPE_EN
  logic             vld_q;
  logic [IDX_W-1:0] wr_idx_q;

  // Write side trails issue by the multiplier's register stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q    <= 1'b0;
      wr_idx_q <= '0;
    end else begin
      vld_q    <= iss;
      wr_idx_q <= idx_q;
    end
  end

  assign wr_en  = vld_q;
  assign wr_idx = wr_idx_q;
`else
  assign wr_en  = iss;
  assign wr_idx = idx_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        res_q         <= '0;
    else if (wr_en) res_q[wr_idx] <= mul_p;
  end

  assign bus.result = res_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_vec_elem_mul.sv
// Directed vector bench for vec_elem_mul (VECTOR_LEN=4), default or pipelined build.
module tb_vec_elem_mul;

  localparam int N = 4;
`ifdef VEC_ELEM_MUL_PIPE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 5;
`endif

  typedef struct {
    string               name;
    logic [N-1:0][31:0]  a;
    logic [N-1:0][31:0]  b;
    logic [N-1:0][31:0]  exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  vec_t tbl[5];

  always #5 clk = ~clk;

  vec_elem_mul_if #(.VECTOR_LEN(N)) bus ();

  vec_elem_mul #(.VECTOR_LEN(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic chk_results(input string nm, input logic [N-1:0][31:0] req);
    for (int i = 0; i < N; i++)
      chk($sformatf("%s result[%0d]", nm, i), bus.result[i], req[i]);
  endtask

  // Edges counted from the capturing edge (1) to the edge after which done is seen.
  task automatic wait_done(input string nm, input int start_n);
    int n = start_n;
    while (!bus.done && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk({nm, " latency"}, 32'(n), 32'(LAT));
  endtask

  task automatic run_vec(input vec_t v);
    bus.vec_a = v.a; bus.vec_b = v.b; bus.enable = 1'b1;
    wait_done(v.name, 0);
    chk_results(v.name, v.exp);
    bus.enable = 1'b0;
    @(posedge clk); #1;
    chk({v.name, " done clears"}, 32'(bus.done), 32'd0);
  endtask

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == '0) d = {f[31], 63'd0};
    else               d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == '0) return {d[63], 31'd0};
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  initial begin
    real sum;

    tbl[0].name = "basic";
    tbl[0].a   = {32'hBFC00000, 32'h40400000, 32'h40000000, 32'h3F800000};
    tbl[0].b   = {32'h40000000, 32'hBF800000, 32'h3F000000, 32'h40000000};
    tbl[0].exp = {32'hC0400000, 32'hC0400000, 32'h3F800000, 32'h40000000};
    tbl[1].name = "special";
    tbl[1].a   = {32'h80000000, 32'h00800000, 32'h7F800000, 32'h7F000000};
    tbl[1].b   = {32'h40000000, 32'h3F000000, 32'h00000000, 32'h7F000000};
    tbl[1].exp = {32'h80000000, 32'h00000000, 32'h7FC00000, 32'h7F800000};
    tbl[2].name = "round";
    tbl[2].a   = {32'hFF800000, 32'h7FC00001, 32'h3FFFFFFF, 32'h3F800001};
    tbl[2].b   = {32'h40000000, 32'h3F800000, 32'h3FFFFFFF, 32'h3F800001};
    tbl[2].exp = {32'hFF800000, 32'h7FC00000, 32'h407FFFFE, 32'h3F800002};
    tbl[3].name = "edge";
    tbl[3].a   = {32'h00000001, 32'h7F7FFFFF, 32'h00800000, 32'h3F7FFFFF};
    tbl[3].b   = {32'h7F000000, 32'hC0000000, 32'h3F800000, 32'h3F800001};
    tbl[3].exp = {32'h00000000, 32'hFF800000, 32'h00800000, 32'h3F800000};
    tbl[4].name = "ones";
    tbl[4].a   = {4{32'h3F800000}};
    tbl[4].b   = {4{32'h3F800000}};
    tbl[4].exp = {4{32'h3F800000}};

    bus.enable = 1'b0; bus.vec_a = '0; bus.vec_b = '0;
    #12;
    chk("reset done", 32'(bus.done), 32'd0);
    chk_results("reset", '0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    for (int t = 0; t < 4; t++) run_vec(tbl[t]);

    // Enable dropped after two RUN edges: run finishes, done lasts one cycle.
    bus.vec_a = tbl[2].a; bus.vec_b = tbl[2].b; bus.enable = 1'b1;
    for (int e = 0; e < 3; e++) begin @(posedge clk); #1; end
    bus.enable = 1'b0;
    wait_done("drop_en", 3);
    chk_results("drop_en", tbl[2].exp);
    @(posedge clk); #1;
    chk("drop_en done one cycle", 32'(bus.done), 32'd0);
    @(posedge clk); #1;
    chk("drop_en stays idle", 32'(bus.done), 32'd0);

    // Enable held; vec_a changed after capture must not leak into results.
    bus.vec_a = tbl[0].a; bus.vec_b = tbl[0].b; bus.enable = 1'b1;
    for (int e = 0; e < 2; e++) begin @(posedge clk); #1; end
    bus.vec_a = {4{32'h40000000}};
    wait_done("hold_en", 2);
    chk_results("hold_en", tbl[0].exp);
    for (int e = 0; e < 3; e++) begin
      @(posedge clk); #1;
      chk("hold_en done held", 32'(bus.done), 32'd1);
    end
    chk_results("hold_en no rerun", tbl[0].exp);
    bus.enable = 1'b0;
    @(posedge clk); #1;
    chk("hold_en release", 32'(bus.done), 32'd0);

    // Asynchronous reset with idx=2 in the default build.
    bus.vec_a = tbl[3].a; bus.vec_b = tbl[3].b; bus.enable = 1'b1;
    for (int e = 0; e < 3; e++) begin @(posedge clk); #1; end
    #1 rst = 1'b1;
    #1;
    chk("midrst done", 32'(bus.done), 32'd0);
    chk_results("midrst", '0);
    bus.enable = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst idle", 32'(bus.done), 32'd0);
    run_vec(tbl[1]);

    // Products feed a downstream summation.
    run_vec(tbl[4]);
    sum = 0.0;
    for (int i = 0; i < N; i++) sum += f2r(bus.result[i]);
    chk("chain sum", r2f(sum), 32'h40800000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
